// File: rtl/mcf_pkg.sv
// Shared width helpers for the multi-channel FIFO with occupancy tracking.
package mcf_pkg;

   // Head/tail pointers carry one wrap bit above the slot index.
   function automatic int ptr_w(input int fifo_size);
      return fifo_size + 1;
   endfunction

   function automatic int cnt_w(input int fifo_size);
      return fifo_size + 1;
   endfunction

   function automatic int addr_w(input int c_log, input int fifo_size);
      return c_log + fifo_size;
   endfunction

   // LSB of channel ch inside the flattened CNT bus.
   function automatic int cnt_lsb(input int ch, input int fifo_size);
      return ch * cnt_w(fifo_size);
   endfunction

endpackage

// File: rtl/mcf_sdp_ram.sv
// Simple-dual-port RAM, read-first, registered output that holds between reads.
module mcf_sdp_ram #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [1<<AW];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge CLK) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Only the output register is reset; the array stays BlockRAM-friendly.
   always_ff @(posedge CLK) begin
      if (!RST_N)    r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/multi_channel_fifo_occ.sv
// 2^C_LOG logical FIFOs over one shared SDP RAM with occupancy, almost-full and
// overflow/underflow protection. MCF_ERR_FLAG_EN enables the sticky error flags.
module multi_channel_fifo_occ
   import mcf_pkg::*;
#(
   parameter int C_LOG      = 2,
   parameter int FIFO_SIZE  = 2,
   parameter int FIFO_WIDTH = 32,
   parameter int AFULL_TH   = (1 << FIFO_SIZE) - 1
) (
   input  logic                                CLK,
   input  logic                                RST_N,
   input  logic                                ENQ,
   input  logic [C_LOG-1:0]                    ENQ_IDX,
   input  logic [FIFO_WIDTH-1:0]               DIN,
   input  logic                                DEQ,
   input  logic [C_LOG-1:0]                    DEQ_IDX,
   output logic [FIFO_WIDTH-1:0]               DOT,
   output logic                                DOT_VLD,
   output logic [C_LOG-1:0]                    DOT_IDX,
   output logic [(1<<C_LOG)-1:0]               EMP,
   output logic [(1<<C_LOG)-1:0]               FULL,
   output logic [(1<<C_LOG)-1:0]               AFULL,
   output logic [(1<<C_LOG)*(FIFO_SIZE+1)-1:0] CNT,
   output logic                                ERR_OVF,
   output logic                                ERR_UDF
);

   localparam int N  = 1 << C_LOG;
   localparam int PW = ptr_w(FIFO_SIZE);
   localparam int CW = cnt_w(FIFO_SIZE);
   localparam int AW = addr_w(C_LOG, FIFO_SIZE);

   logic [PW-1:0]    r_head [N];
   logic [PW-1:0]    r_tail [N];
   logic [CW-1:0]    w_cnt  [N];
   logic [N-1:0]     w_emp;
   logic [N-1:0]     w_full;
   logic             w_deq_ok;
   logic             w_enq_ok;
   logic             w_same;
   logic [AW-1:0]    w_waddr;
   logic [AW-1:0]    w_raddr;
   logic             r_dot_vld;
   logic [C_LOG-1:0] r_dot_idx;

   for (genvar g = 0; g < N; g++) begin : g_ch
      localparam int LSB = cnt_lsb(g, FIFO_SIZE);
      assign w_emp[g]  = (r_head[g] == r_tail[g]);
      assign w_full[g] = (r_head[g] == {~r_tail[g][PW-1], r_tail[g][PW-2:0]});
      assign w_cnt[g]  = r_tail[g] - r_head[g];
      assign AFULL[g]  = (int'(w_cnt[g]) >= AFULL_TH);
      assign CNT[LSB +: CW] = w_cnt[g];
   end

   assign EMP  = w_emp;
   assign FULL = w_full;

   // A full channel may still enqueue when the same channel is drained this cycle.
   assign w_same   = (ENQ_IDX == DEQ_IDX);
   assign w_deq_ok = DEQ & ~w_emp[DEQ_IDX];
   assign w_enq_ok = ENQ & (~w_full[ENQ_IDX] | (w_deq_ok & w_same));

   assign w_waddr = {ENQ_IDX, r_tail[ENQ_IDX][PW-2:0]};
   assign w_raddr = {DEQ_IDX, r_head[DEQ_IDX][PW-2:0]};

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < N; i++) begin
            r_head[i] <= '0;
            r_tail[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_enq_ok && (ENQ_IDX == C_LOG'(i))) r_tail[i] <= r_tail[i] + PW'(1);
            if (w_deq_ok && (DEQ_IDX == C_LOG'(i))) r_head[i] <= r_head[i] + PW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_dot_vld <= 1'b0;
         r_dot_idx <= '0;
      end else begin
         r_dot_vld <= w_deq_ok;
         if (w_deq_ok) r_dot_idx <= DEQ_IDX;
      end
   end

   assign DOT_VLD = r_dot_vld;
   assign DOT_IDX = r_dot_idx;

   mcf_sdp_ram #(
      .AW (AW),
      .DW (FIFO_WIDTH)
   ) u_ram (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_we    (w_enq_ok & RST_N),
      .i_waddr (w_waddr),
      .i_wdata (DIN),
      .i_re    (w_deq_ok & RST_N),
      .i_raddr (w_raddr),
      .o_rdata (DOT)
   );

`ifdef MCF_ERR_FLAG_EN
   logic r_err_ovf;
   logic r_err_udf;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_err_ovf <= 1'b0;
         r_err_udf <= 1'b0;
      end else begin
         if (ENQ && !w_enq_ok) r_err_ovf <= 1'b1;
         if (DEQ && !w_deq_ok) r_err_udf <= 1'b1;
      end
   end

   assign ERR_OVF = r_err_ovf;
   assign ERR_UDF = r_err_udf;
`else
   assign ERR_OVF = 1'b0;
   assign ERR_UDF = 1'b0;
`endif

endmodule

// File: tb/tb_multi_channel_fifo_occ.sv
// Self-checking bench for multi_channel_fifo_occ: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_multi_channel_fifo_occ;

   localparam int C_LOG = 2;
   localparam int FS    = 2;
   localparam int W     = 32;
   localparam int N     = 1 << C_LOG;
   localparam int DEPTH = 1 << FS;
   localparam int ATH   = DEPTH - 1;
   localparam int CW    = FS + 1;
`ifdef MCF_ERR_FLAG_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                CLK = 1'b0;
   logic                RST_N;
   logic                ENQ;
   logic [C_LOG-1:0]    ENQ_IDX;
   logic [W-1:0]        DIN;
   logic                DEQ;
   logic [C_LOG-1:0]    DEQ_IDX;
   logic [W-1:0]        DOT;
   logic                DOT_VLD;
   logic [C_LOG-1:0]    DOT_IDX;
   logic [N-1:0]        EMP, FULL, AFULL;
   logic [N*CW-1:0]     CNT;
   logic                ERR_OVF, ERR_UDF;

   multi_channel_fifo_occ #(
      .C_LOG(C_LOG), .FIFO_SIZE(FS), .FIFO_WIDTH(W), .AFULL_TH(ATH)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .ENQ(ENQ), .ENQ_IDX(ENQ_IDX), .DIN(DIN),
      .DEQ(DEQ), .DEQ_IDX(DEQ_IDX), .DOT(DOT), .DOT_VLD(DOT_VLD), .DOT_IDX(DOT_IDX),
      .EMP(EMP), .FULL(FULL), .AFULL(AFULL), .CNT(CNT),
      .ERR_OVF(ERR_OVF), .ERR_UDF(ERR_UDF)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: one queue per channel plus output/error state.
   logic [W-1:0] mq [N][$];
   logic [W-1:0] m_dot;
   bit           m_vld;
   int           m_idx;
   bit           m_ovf, m_udf;

   typedef struct {
      bit enq; int eidx; int din; bit deq; int didx;
      bit vld; int dot; int cch; int ccnt; bit ovf; bit udf;
   } vec_t;
   vec_t vecs[$];

   function automatic void addv(bit enq, int ei, int din, bit deq, int di,
                                bit vld, int dot, int cch, int ccnt, bit ovf, bit udf);
      vec_t v;
      v = '{enq, ei, din, deq, di, vld, dot, cch, ccnt, ovf, udf};
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cnt_of(int ch);
      logic [N*CW-1:0] c;
      c = CNT;
      return int'(c[ch*CW +: CW]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mq[i].delete();
      m_dot = '0; m_vld = 0; m_idx = 0; m_ovf = 0; m_udf = 0;
   endtask

   task automatic model_step(bit enq, int ei, logic [W-1:0] din, bit deq, int di);
      bit deq_ok, enq_ok;
      deq_ok = deq && (mq[di].size() != 0);
      enq_ok = enq && ((mq[ei].size() < DEPTH) || (deq_ok && di == ei));
      if (deq && !deq_ok) m_udf = 1;
      if (enq && !enq_ok) m_ovf = 1;
      m_vld = deq_ok;
      if (deq_ok) begin
         m_dot = mq[di].pop_front();
         m_idx = di;
      end
      if (enq_ok) mq[ei].push_back(din);
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("cnt[%0d]", i), W'(cnt_of(i)), W'(mq[i].size()));
         chk($sformatf("emp[%0d]", i), W'(EMP[i]), W'(mq[i].size() == 0));
         chk($sformatf("full[%0d]", i), W'(FULL[i]), W'(mq[i].size() == DEPTH));
         chk($sformatf("afull[%0d]", i), W'(AFULL[i]), W'(mq[i].size() >= ATH));
      end
      chk("dot_vld", W'(DOT_VLD), W'(m_vld));
      chk("dot", DOT, m_dot);
      if (m_vld) chk("dot_idx", W'(DOT_IDX), W'(m_idx));
      chk("err_ovf", W'(ERR_OVF), W'(m_ovf & ERR_EN));
      chk("err_udf", W'(ERR_UDF), W'(m_udf & ERR_EN));
   endtask

   task automatic cycle(bit enq, int ei, logic [W-1:0] din, bit deq, int di);
      ENQ = enq; ENQ_IDX = C_LOG'(ei); DIN = din;
      DEQ = deq; DEQ_IDX = C_LOG'(di);
      @(posedge CLK); #1;
      model_step(enq, ei, din, deq, di);
      check_all();
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      ENQ = 1'b1; ENQ_IDX = 1; DIN = 32'hDEAD; DEQ = 1'b1; DEQ_IDX = 0;
      @(posedge CLK); #1;
      model_reset();
      check_all();
      chk("rst_dot_idx", W'(DOT_IDX), 0);
      RST_N = 1'b1;
      ENQ = 1'b0; DEQ = 1'b0;
   endtask

   initial begin
      ENQ = 0; ENQ_IDX = 0; DIN = 0; DEQ = 0; DEQ_IDX = 0; RST_N = 0;
      model_reset();
      #1;
      do_reset();
      do_reset();

      //    enq ei din     deq di | vld dot     cch cnt ovf udf
      addv(1, 2, 'h11, 0, 0,   0, 0,     2, 1, 0, 0);
      addv(1, 2, 'h22, 0, 0,   0, 0,     2, 2, 0, 0);
      addv(1, 2, 'h33, 0, 0,   0, 0,     2, 3, 0, 0);
      addv(1, 2, 'h44, 0, 0,   0, 0,     2, 4, 0, 0);
      addv(1, 2, 'h55, 0, 0,   0, 0,     2, 4, 1, 0);
      addv(0, 0, 0,    1, 2,   1, 'h11,  2, 3, 1, 0);
      addv(0, 0, 0,    1, 2,   1, 'h22,  2, 2, 1, 0);
      addv(0, 0, 0,    1, 2,   1, 'h33,  2, 1, 1, 0);
      addv(0, 0, 0,    1, 2,   1, 'h44,  2, 0, 1, 0);
      addv(0, 0, 0,    0, 0,   0, 'h44,  2, 0, 1, 0);
      addv(1, 1, 'hA0, 0, 0,   0, 'h44,  1, 1, 1, 0);
      addv(1, 1, 'hA1, 0, 0,   0, 'h44,  1, 2, 1, 0);
      addv(1, 1, 'hA2, 0, 0,   0, 'h44,  1, 3, 1, 0);
      addv(1, 1, 'hA3, 0, 0,   0, 'h44,  1, 4, 1, 0);
      addv(1, 1, 'hA4, 1, 1,   1, 'hA0,  1, 4, 1, 0);
      addv(0, 0, 0,    1, 1,   1, 'hA1,  1, 3, 1, 0);
      addv(0, 0, 0,    1, 1,   1, 'hA2,  1, 2, 1, 0);
      addv(0, 0, 0,    1, 1,   1, 'hA3,  1, 1, 1, 0);
      addv(0, 0, 0,    1, 1,   1, 'hA4,  1, 0, 1, 0);
      addv(1, 3, 'h77, 1, 3,   0, 'hA4,  3, 1, 1, 1);
      addv(0, 0, 0,    1, 3,   1, 'h77,  3, 0, 1, 1);

      foreach (vecs[k]) begin
         cycle(vecs[k].enq, vecs[k].eidx, W'(vecs[k].din), vecs[k].deq, vecs[k].didx);
         chk($sformatf("v%0d_vld", k), W'(DOT_VLD), W'(vecs[k].vld));
         chk($sformatf("v%0d_dot", k), DOT, W'(vecs[k].dot));
         if (vecs[k].vld) chk($sformatf("v%0d_idx", k), W'(DOT_IDX), W'(vecs[k].didx));
         chk($sformatf("v%0d_cnt", k), W'(cnt_of(vecs[k].cch)), W'(vecs[k].ccnt));
         chk($sformatf("v%0d_ovf", k), W'(ERR_OVF), W'(vecs[k].ovf & ERR_EN));
         chk($sformatf("v%0d_udf", k), W'(ERR_UDF), W'(vecs[k].udf & ERR_EN));
      end
      chk("afull2_after3", W'(ATH), 3);

      // Ten enqueue/dequeue pairs on ch0, crossing pointer wraps.
      for (int k = 0; k < 10; k++) begin
         cycle(1, 0, W'(32'h100 + k), 0, 0);
         cycle(0, 0, 0, 1, 0);
         chk($sformatf("wrap_dot%0d", k), DOT, W'(32'h100 + k));
      end
      chk("wrap_emp0", W'(EMP[0]), 1);

      // Back-to-back dequeue at full rate after filling ch0 past a wrap.
      for (int k = 0; k < DEPTH; k++) cycle(1, 0, W'(32'h200 + k), 0, 0);
      for (int k = 0; k < DEPTH; k++) begin
         cycle(0, 0, 0, 1, 0);
         chk($sformatf("b2b_dot%0d", k), DOT, W'(32'h200 + k));
      end

      // Reset mid-operation: ch0 holds two words and DOT_VLD is high.
      cycle(1, 0, 'hC1, 0, 0);
      cycle(1, 0, 'hC2, 0, 0);
      cycle(1, 0, 'hC3, 0, 0);
      cycle(0, 0, 0, 1, 0);
      chk("pre_rst_vld", W'(DOT_VLD), 1);
      chk("pre_rst_cnt0", W'(cnt_of(0)), 2);
      do_reset();
      for (int i = 0; i < N; i++) chk($sformatf("rst_cnt%0d", i), W'(cnt_of(i)), 0);
      chk("rst_vld", W'(DOT_VLD), 0);
      chk("rst_err", W'({ERR_OVF, ERR_UDF}), 0);

      // Randomized traffic against the model.
      for (int k = 0; k < 800; k++) begin
         bit re, rd;
         int ei, di;
         re = ($urandom_range(0, 99) < 55);
         rd = ($urandom_range(0, 99) < 45);
         ei = int'($urandom_range(0, N - 1));
         di = ($urandom_range(0, 3) == 0) ? ei : int'($urandom_range(0, N - 1));
         cycle(re, ei, W'($urandom), rd, di);
         if (k == 400) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
